spi_alu_slave: RTL and testbench

// Parametrised SPI-slave ALU for the serial processor; successor of the fixed 3-op ALU. Processor (SPI master) shifts
// in an operation packet one bit per i_clock, ALU computes one result, shifts back result plus optional NZCV flags.

---
 rtl/spi_alu_slave_if.sv | 11 +
 rtl/spi_alu_slave.sv | 125 ++++++++++++
 tb/tb_spi_alu_slave.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/spi_alu_slave_if.sv
// spi_alu_slave_if: select/data/status signals between the SPI master and the ALU slave
interface spi_alu_slave_if #(
  parameter int NssWidth = 1
) ();
  logic [NssWidth-1:0] i_nss;
  logic                i_mosi;
  logic                o_busy;
  logic                o_illegal_op;
  modport master (output i_nss, i_mosi, input o_busy, o_illegal_op);
  modport slave (input i_nss, i_mosi, output o_busy, o_illegal_op);
endinterface

// File: rtl/spi_alu_slave.sv
// spi_alu_slave: bit-serial SPI slave that receives an op packet, computes one ALU result and returns it with NZCV flags
module spi_alu_slave #(
  parameter int DataWidth   = 8,
  parameter int OpWidth     = 3,
  parameter int NssWidth    = 1,
  parameter int NssPosition = 0,
  parameter int FlagsEnable = 1
) (
  input  logic           i_clock,
  input  logic           i_reset,
  spi_alu_slave_if.slave bus,
  output logic           o_miso
);
  localparam int InBits  = OpWidth + 2 * DataWidth;
  localparam int OutBits = DataWidth + ((FlagsEnable != 0) ? 4 : 0);
  localparam int InCw    = $clog2(InBits);
  localparam int OutCw   = $clog2(OutBits);
  localparam int Msb     = DataWidth - 1;
  localparam logic [OpWidth-1:0] OpAdd = OpWidth'(0);
  localparam logic [OpWidth-1:0] OpSub = OpWidth'(1);
  localparam logic [OpWidth-1:0] OpAnd = OpWidth'(2);
  localparam logic [OpWidth-1:0] OpOr  = OpWidth'(3);
  localparam logic [OpWidth-1:0] OpXor = OpWidth'(4);
  localparam logic [OpWidth-1:0] OpShl = OpWidth'(5);
  localparam logic [OpWidth-1:0] OpShr = OpWidth'(6);
  typedef enum logic [2:0] {IDLE, RECEIVING, OPERATE, READY, SENDING} state_e;
  state_e              state_q, state_d;
  logic [InCw-1:0]     cnt_in_q, cnt_in_d;
  logic [OutCw-1:0]    cnt_out_q, cnt_out_d;
  logic [InBits-1:0]   in_packet_q, in_packet_d;
  logic [OutBits-1:0]  out_packet_q, out_packet_d;
  logic                illegal_q, illegal_d;
  logic [NssWidth-1:0] nss;
  logic                active, miso_bit;
  logic [OpWidth-1:0]  op;
  logic [Msb:0]        op1, op2, res;
  logic [DataWidth:0]  sum, diff;
  logic                legal, z, n, c, v;
  assign nss                = bus.i_nss;
  assign active             = !nss[NssPosition];
  assign op                 = in_packet_q[OpWidth-1:0];
  assign op1                = in_packet_q[OpWidth +: DataWidth];
  assign op2                = in_packet_q[OpWidth+DataWidth +: DataWidth];
  assign o_miso             = active ? miso_bit : 1'bz;
  assign bus.o_busy         = state_q != IDLE;
  assign bus.o_illegal_op   = illegal_q;
  // ALU datapath: result and NZCV flags from the received packet; shifts past the width yield 0
  always_comb begin
    sum   = {1'b0, op1} + {1'b0, op2};
    diff  = {1'b0, op1} - {1'b0, op2};
    legal = op <= OpShr;
    res   = op == OpAdd ? sum[Msb:0] :
            op == OpSub ? diff[Msb:0] :
            op == OpAnd ? op1 & op2 :
            op == OpOr  ? op1 | op2 :
            op == OpXor ? op1 ^ op2 :
            op == OpShl ? op1 << op2 :
            op == OpShr ? op1 >> op2 : '0;
    z     = legal && (res == '0);
    n     = res[Msb];
    c     = op == OpAdd ? sum[DataWidth] : op == OpSub ? diff[DataWidth] : 1'b0;
    v     = op == OpAdd ? (op1[Msb] == op2[Msb]) && (res[Msb] != op1[Msb]) :
            op == OpSub ? (op1[Msb] != op2[Msb]) && (res[Msb] != op1[Msb]) : 1'b0;
  end
  // Next-state, counters, packet capture and serial output bit
  always_comb begin
    state_d      = state_q;
    cnt_in_d     = cnt_in_q;
    cnt_out_d    = cnt_out_q;
    in_packet_d  = in_packet_q;
    out_packet_d = out_packet_q;
    illegal_d    = 1'b0;
    miso_bit     = 1'b0;
    case (state_q)
      IDLE: state_d = (active && bus.i_mosi) ? RECEIVING : IDLE;
      RECEIVING: begin
        if (!active) begin
          state_d  = IDLE;
          cnt_in_d = '0;
        end else begin
          in_packet_d[cnt_in_q] = bus.i_mosi;
          state_d  = (cnt_in_q == InCw'(InBits - 1)) ? OPERATE : RECEIVING;
          cnt_in_d = (cnt_in_q == InCw'(InBits - 1)) ? '0 : cnt_in_q + 1'b1;
        end
      end
      OPERATE: begin
        out_packet_d = OutBits'({v, c, n, z, res});
        illegal_d    = !legal;
        state_d      = READY;
      end
      READY: begin
        miso_bit = 1'b1;
        state_d  = (active && !bus.i_mosi) ? SENDING : READY;
      end
      SENDING: begin
        miso_bit  = out_packet_q[cnt_out_q];
        state_d   = (!active || cnt_out_q == OutCw'(OutBits - 1)) ? IDLE : SENDING;
        cnt_out_d = (!active || cnt_out_q == OutCw'(OutBits - 1)) ? '0 : cnt_out_q + 1'b1;
      end
      default: begin
        state_d   = IDLE;
        cnt_in_d  = '0;
        cnt_out_d = '0;
      end
    endcase
  end
  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      cnt_in_q     <= '0;
      cnt_out_q    <= '0;
      in_packet_q  <= '0;
      out_packet_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_in_q     <= cnt_in_d;
      cnt_out_q    <= cnt_out_d;
      in_packet_q  <= in_packet_d;
      out_packet_q <= out_packet_d;
      illegal_q    <= illegal_d;
    end
  end
endmodule

// File: tb/tb_spi_alu_slave.sv
// tb_spi_alu_slave: directed self-checking bench for the SPI ALU slave
module tb_spi_alu_slave;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_miso;
  logic [11:0] r;
  logic        ill1;
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  spi_alu_slave_if #(.NssWidth(2)) bus ();
  spi_alu_slave #(
    .DataWidth(8), .OpWidth(3), .NssWidth(2), .NssPosition(0), .FlagsEnable(1)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus(bus),
    .o_miso(o_miso)
  );
  always #5 i_clock = ~i_clock;
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [18:0] p;
    p = {b, a, op};
    bus.i_mosi = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      bus.i_mosi = p[i];
      tick();
    end
    bus.i_mosi = 1'b0;
    tick();
  endtask
  task automatic unload();
    r = '0;
    bus.i_mosi = 1'b0;
    tick();
    ill1 = bus.o_illegal_op;
    for (int i = 0; i < 12; i++) begin
      r[i] = o_miso;
      tick();
    end
  endtask
  task automatic xact(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] ef, input logic ei, input string tag);
    load(op, a, b);
    chk({tag, "_busy"}, bus.o_busy, 1);
    chk({tag, "_miso_ready"}, o_miso, 1);
    chk({tag, "_illegal"}, bus.o_illegal_op, ei);
    unload();
    chk({tag, "_illegal_next"}, ill1, 0);
    chk({tag, "_result"}, r[7:0], er);
    chk({tag, "_flags"}, r[11:8], ef);
    chk({tag, "_idle"}, bus.o_busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.i_nss  = 2'b10;
    bus.i_mosi = 1'b0;
    #1 i_reset = 1'b0;
    #2;
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_illegal", bus.o_illegal_op, 0);
    chk("reset_miso", o_miso, 0);
    tick();
    i_reset = 1'b1;
    tick();
    xact(3'd0, 8'hF0, 8'h20, 8'h10, 4'h4, 1'b0, "add_carry");
    xact(3'd0, 8'h7F, 8'h01, 8'h80, 4'hA, 1'b0, "add_ovf");
    xact(3'd1, 8'h05, 8'h07, 8'hFE, 4'h6, 1'b0, "sub_borrow");
    xact(3'd1, 8'h33, 8'h33, 8'h00, 4'h1, 1'b0, "sub_zero");
    xact(3'd2, 8'hF0, 8'h3C, 8'h30, 4'h0, 1'b0, "and");
    xact(3'd3, 8'h0F, 8'h80, 8'h8F, 4'h2, 1'b0, "or");
    xact(3'd4, 8'hAA, 8'hFF, 8'h55, 4'h0, 1'b0, "xor");
    xact(3'd5, 8'h01, 8'h03, 8'h08, 4'h0, 1'b0, "shl3");
    xact(3'd5, 8'h01, 8'h09, 8'h00, 4'h1, 1'b0, "shl9");
    xact(3'd6, 8'h80, 8'h07, 8'h01, 4'h0, 1'b0, "shr7");
    xact(3'd7, 8'h12, 8'h34, 8'h00, 4'h0, 1'b1, "illegal");
    xact(3'd0, 8'h01, 8'h01, 8'h02, 4'h0, 1'b0, "after_illegal");
    bus.i_mosi = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.i_mosi = i[0];
      tick();
    end
    bus.i_nss = 2'b11;
    tick();
    chk("abort_rx_busy", bus.o_busy, 0);
    bus.i_nss  = 2'b10;
    bus.i_mosi = 1'b0;
    tick();
    xact(3'd0, 8'h03, 8'h04, 8'h07, 4'h0, 1'b0, "after_abort");
    load(3'd0, 8'h10, 8'h22);
    bus.i_nss = 2'b11;
    #1;
    chk("ready_released_not_driven", o_miso === 1'b1, 0);
    tick();
    tick();
    chk("ready_wait_busy", bus.o_busy, 1);
    bus.i_nss = 2'b10;
    #1;
    chk("ready_reselect_miso", o_miso, 1);
    unload();
    chk("ready_kept_result", r[7:0], 8'h32);
    chk("ready_kept_flags", r[11:8], 4'h0);
    load(3'd1, 8'h10, 8'h01);
    bus.i_mosi = 1'b0;
    tick();
    for (int i = 0; i < 11; i++) tick();
    bus.i_nss = 2'b11;
    tick();
    chk("abort_last_bit_busy", bus.o_busy, 0);
    bus.i_nss  = 2'b01;
    bus.i_mosi = 1'b1;
    tick();
    tick();
    chk("other_slave_busy", bus.o_busy, 0);
    bus.i_nss  = 2'b10;
    bus.i_mosi = 1'b0;
    tick();
    load(3'd0, 8'h01, 8'h02);
    bus.i_mosi = 1'b0;
    tick();
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    chk("reset_mid_send_busy", bus.o_busy, 0);
    chk("reset_mid_send_miso", o_miso, 0);
    tick();
    i_reset = 1'b1;
    tick();
    xact(3'd4, 8'h0F, 8'hF0, 8'hFF, 4'h2, 1'b0, "b2b_first");
    xact(3'd1, 8'h80, 8'h01, 8'h7F, 4'h8, 1'b0, "b2b_second");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
